// File: rtl/alu_pkg.sv
// ALU control codes, ALU-op encoding and default widths shared by the EX operand-issue slice.
package alu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101,
    ALU_NOP = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_FUNCT = 2'b10,
    OP_RSVD  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/ex_operand_issue_if.sv
// Decode-side, forward-source and EX-side signal bundle for ex_operand_issue.
interface ex_operand_issue_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              d_valid;
  logic [XLEN-1:0]   d_rd1;
  logic [XLEN-1:0]   d_rd2;
  logic [XLEN-1:0]   d_imm_ext;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic [REG_AW-1:0] d_rd;
  logic              d_reg_write;
  logic              d_alu_src_b;
  logic [1:0]        d_alu_op;
  logic [2:0]        d_funct3;
  logic              d_funct7b5;
  logic              d_op5;
  logic [REG_AW-1:0] m_rd;
  logic              m_reg_write;
  logic [XLEN-1:0]   m_result;
  logic [REG_AW-1:0] w_rd;
  logic              w_reg_write;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [2:0]        alu_control;
  logic              e_valid;
  logic [REG_AW-1:0] e_rd;
  logic              e_reg_write;
  logic [XLEN-1:0]   e_write_data;
  logic              e_illegal;

  modport master (
    output stall, flush, d_valid, d_rd1, d_rd2, d_imm_ext, d_rs1, d_rs2, d_rd,
           d_reg_write, d_alu_src_b, d_alu_op, d_funct3, d_funct7b5, d_op5,
           m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_result,
    input  src_a, src_b, alu_control, e_valid, e_rd, e_reg_write, e_write_data, e_illegal
  );

  modport slave (
    input  stall, flush, d_valid, d_rd1, d_rd2, d_imm_ext, d_rs1, d_rs2, d_rd,
           d_reg_write, d_alu_src_b, d_alu_op, d_funct3, d_funct7b5, d_op5,
           m_rd, m_reg_write, m_result, w_rd, w_reg_write, w_result,
    output src_a, src_b, alu_control, e_valid, e_rd, e_reg_write, e_write_data, e_illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU-op/funct decode to ALU control code plus illegal-encoding flag.
module alu_decoder
  import alu_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output alu_ctrl_t  alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_NOP;
    illegal     = 1'b0;
    case (alu_op)
      OP_ADD: alu_control = ALU_ADD;
      OP_SUB: alu_control = ALU_SUB;
      OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal     = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_operand_issue.sv
// ID/EX register and ALU operand producer with optional MEM/WB forwarding.
// Build with OPERAND_FWD_EN defined to enable forwarding; otherwise operands come from read data.
module ex_operand_issue
  import alu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  ex_operand_issue_if.slave   io
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic              alu_src_b;
    alu_ctrl_t         ctrl;
    logic              illegal;
  } ex_reg_t;

  ex_reg_t         r;
  alu_ctrl_t       dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  alu_decoder u_dec (
    .alu_op      (alu_op_t'(io.d_alu_op)),
    .funct3      (io.d_funct3),
    .funct7b5    (io.d_funct7b5),
    .op5         (io.d_op5),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  // Bubbles (flush or an invalid decode slot) only clear control; data fields are don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r.valid     <= 1'b0;
      r.reg_write <= 1'b0;
      r.rd        <= '0;
      r.rs1       <= '0;
      r.rs2       <= '0;
      r.rd1       <= '0;
      r.rd2       <= '0;
      r.imm       <= '0;
      r.alu_src_b <= 1'b0;
      r.ctrl      <= ALU_NOP;
      r.illegal   <= 1'b0;
    end else if (io.flush || (!io.stall && !io.d_valid)) begin
      r.valid     <= 1'b0;
      r.reg_write <= 1'b0;
      r.ctrl      <= ALU_NOP;
      r.illegal   <= 1'b0;
    end else if (!io.stall) begin
      r.valid     <= 1'b1;
      r.reg_write <= io.d_reg_write;
      r.rd        <= io.d_rd;
      r.rs1       <= io.d_rs1;
      r.rs2       <= io.d_rs2;
      r.rd1       <= io.d_rd1;
      r.rd2       <= io.d_rd2;
      r.imm       <= io.d_imm_ext;
      r.alu_src_b <= io.d_alu_src_b;
      r.ctrl      <= dec_ctrl;
      r.illegal   <= dec_illegal;
    end
  end

`ifdef OPERAND_FWD_EN
  // MEM is the younger producer, so it wins a double match; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = r.rd1;
    if (io.m_reg_write && (io.m_rd == r.rs1) && (r.rs1 != '0))
      fwd_a = io.m_result;
    else if (io.w_reg_write && (io.w_rd == r.rs1) && (r.rs1 != '0))
      fwd_a = io.w_result;
  end

  always_comb begin
    fwd_b = r.rd2;
    if (io.m_reg_write && (io.m_rd == r.rs2) && (r.rs2 != '0))
      fwd_b = io.m_result;
    else if (io.w_reg_write && (io.w_rd == r.rs2) && (r.rs2 != '0))
      fwd_b = io.w_result;
  end
`else
  logic unused_fwd;
  assign fwd_a      = r.rd1;
  assign fwd_b      = r.rd2;
  assign unused_fwd = ^{io.m_rd, io.m_reg_write, io.m_result,
                        io.w_rd, io.w_reg_write, io.w_result, r.rs1, r.rs2};
`endif

  assign io.src_a        = fwd_a;
  assign io.src_b        = r.alu_src_b ? r.imm : fwd_b;
  assign io.e_write_data = fwd_b;
  assign io.alu_control  = r.ctrl;
  assign io.e_valid      = r.valid;
  assign io.e_rd         = r.rd;
  assign io.e_reg_write  = r.reg_write & r.valid;
  assign io.e_illegal    = r.illegal;

endmodule

// File: tb/tb_ex_operand_issue.sv
// Randomized + directed bench for ex_operand_issue against a behavioural model of the EX stage.
module tb_ex_operand_issue;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_operand_issue_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  ex_operand_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int tests = 0;
  int fails = 0;

  // model of the instruction currently held in EX
  logic        mv, mrw, mill, msb;
  logic [2:0]  mctl;
  logic [4:0]  mrd, mrs1, mrs2;
  logic [31:0] m1, m2, mi;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // returns {illegal, alu_control}
  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7, input logic o5);
    if (op == 2'd0) return 4'b0_000;
    if (op == 2'd1) return 4'b0_001;
    if (op == 2'd3) return 4'b1_111;
    if (f3 == 3'd0) return (o5 && f7) ? 4'b0_001 : 4'b0_000;
    if (f3 == 3'd2) return 4'b0_101;
    if (f3 == 3'd6) return 4'b0_011;
    if (f3 == 3'd7) return 4'b0_010;
    return 4'b1_111;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
`ifdef OPERAND_FWD_EN
    if (rs != 0 && bus.m_reg_write && bus.m_rd == rs) return bus.m_result;
    if (rs != 0 && bus.w_reg_write && bus.w_rd == rs) return bus.w_result;
`endif
    return regval;
  endfunction

  task automatic model_reset();
    mv = 0; mrw = 0; mill = 0; msb = 0; mctl = 3'b111;
    mrd = 0; mrs1 = 0; mrs2 = 0; m1 = 0; m2 = 0; mi = 0;
  endtask

  task automatic model_edge();
    if (reset) model_reset();
    else if (bus.flush || (!bus.stall && !bus.d_valid)) begin
      mv = 0; mrw = 0; mctl = 3'b111; mill = 0;
    end else if (!bus.stall) begin
      mv = 1; mrw = bus.d_reg_write; mrd = bus.d_rd;
      mrs1 = bus.d_rs1; mrs2 = bus.d_rs2;
      m1 = bus.d_rd1; m2 = bus.d_rd2; mi = bus.d_imm_ext; msb = bus.d_alu_src_b;
      {mill, mctl} = ref_dec(bus.d_alu_op, bus.d_funct3, bus.d_funct7b5, bus.d_op5);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea, eb;
    ea = fwd(mrs1, m1);
    eb = fwd(mrs2, m2);
    chk("e_valid", {31'd0, bus.e_valid}, {31'd0, mv});
    chk("e_reg_write", {31'd0, bus.e_reg_write}, {31'd0, mrw & mv});
    chk("alu_control", {29'd0, bus.alu_control}, {29'd0, mctl});
    chk("e_illegal", {31'd0, bus.e_illegal}, {31'd0, mill});
    if (mv) begin
      chk("e_rd", {27'd0, bus.e_rd}, {27'd0, mrd});
      chk("src_a", bus.src_a, ea);
      chk("src_b", bus.src_b, msb ? mi : eb);
      chk("e_write_data", bus.e_write_data, eb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic load(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic o5,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic sb);
    bus.d_valid = 1; bus.d_reg_write = 1; bus.d_alu_op = op; bus.d_funct3 = f3;
    bus.d_funct7b5 = f7; bus.d_op5 = o5; bus.d_rs1 = rs1; bus.d_rs2 = rs2; bus.d_rd = rd;
    bus.d_rd1 = a; bus.d_rd2 = b; bus.d_imm_ext = imm; bus.d_alu_src_b = sb;
  endtask

  task automatic no_fwd();
    bus.m_reg_write = 0; bus.w_reg_write = 0;
    bus.m_rd = 0; bus.w_rd = 0; bus.m_result = 0; bus.w_result = 0;
  endtask

  initial begin
    reset = 1; bus.stall = 0; bus.flush = 0;
    load(2'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.d_valid = 0;
    no_fwd();
    model_reset();
    #12;
    chk("rst_e_valid", {31'd0, bus.e_valid}, 32'd0);
    chk("rst_alu_control", {29'd0, bus.alu_control}, 32'd7);
    chk("rst_src_a", bus.src_a, 32'd0);
    chk("rst_src_b", bus.src_b, 32'd0);
    chk("rst_e_write_data", bus.e_write_data, 32'd0);
    @(negedge clk) reset = 0;

    // R-type sub
    load(2'b10, 3'b000, 1, 1, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3, 32'd0, 0);
    step();
    chk("sub_ctrl", {29'd0, bus.alu_control}, 32'd1);
    chk("sub_src_a", bus.src_a, 32'd7);
    chk("sub_src_b", bus.src_b, 32'd3);

    // MEM vs WB priority on rs1=5
    load(2'b00, 3'd0, 0, 0, 5'd5, 5'd6, 5'd4, 32'h99, 32'h55, 32'd0, 0);
    step();
    bus.m_rd = 5; bus.m_reg_write = 1; bus.m_result = 32'h10;
    bus.w_rd = 5; bus.w_reg_write = 1; bus.w_result = 32'h20;
    #1;
`ifdef OPERAND_FWD_EN
    chk("fwd_mem", bus.src_a, 32'h10);
`else
    chk("fwd_mem", bus.src_a, 32'h99);
`endif
    bus.m_reg_write = 0;
    #1;
`ifdef OPERAND_FWD_EN
    chk("fwd_wb", bus.src_a, 32'h20);
`else
    chk("fwd_wb", bus.src_a, 32'h99);
`endif
    no_fwd();

    // x0 never forwarded
    load(2'b00, 3'd0, 0, 0, 5'd0, 5'd0, 5'd4, 32'h1234, 32'h0, 32'd0, 0);
    bus.m_rd = 0; bus.m_reg_write = 1; bus.m_result = 32'hFF;
    step();
    chk("x0_src_a", bus.src_a, 32'h1234);
    no_fwd();

    // stall holds, stall&flush bubbles
    load(2'b01, 3'd0, 0, 0, 5'd1, 5'd2, 5'd9, 32'hA, 32'hB, 32'd0, 0);
    step();
    bus.stall = 1;
    load(2'b11, 3'd5, 1, 1, 5'd7, 5'd8, 5'd10, 32'hC, 32'hD, 32'hE, 1);
    step();
    step();
    chk("stall_ctrl", {29'd0, bus.alu_control}, 32'd1);
    chk("stall_rd", {27'd0, bus.e_rd}, 32'd9);
    chk("stall_src_a", bus.src_a, 32'hA);
    bus.flush = 1;
    step();
    chk("sf_e_valid", {31'd0, bus.e_valid}, 32'd0);
    chk("sf_e_reg_write", {31'd0, bus.e_reg_write}, 32'd0);
    chk("sf_ctrl", {29'd0, bus.alu_control}, 32'd7);
    bus.stall = 0; bus.flush = 0;

    // reserved op, immediate operand
    load(2'b11, 3'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'hFFFF_FFFC, 1);
    step();
    chk("rsvd_ctrl", {29'd0, bus.alu_control}, 32'd7);
    chk("rsvd_illegal", {31'd0, bus.e_illegal}, 32'd1);
    chk("imm_src_b", bus.src_b, 32'hFFFF_FFFC);

    for (int i = 0; i < 400; i++) begin
      bus.d_valid = ($urandom_range(0, 9) != 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.d_alu_op = 2'($urandom_range(0, 3));
      bus.d_funct3 = 3'($urandom_range(0, 7));
      bus.d_funct7b5 = 1'($urandom);
      bus.d_op5 = 1'($urandom);
      bus.d_rs1 = 5'($urandom_range(0, 3));
      bus.d_rs2 = 5'($urandom_range(0, 3));
      bus.d_rd = 5'($urandom);
      bus.d_reg_write = 1'($urandom);
      bus.d_alu_src_b = 1'($urandom);
      bus.d_rd1 = $urandom; bus.d_rd2 = $urandom; bus.d_imm_ext = $urandom;
      bus.m_rd = 5'($urandom_range(0, 3)); bus.m_reg_write = 1'($urandom);
      bus.m_result = $urandom;
      bus.w_rd = 5'($urandom_range(0, 3)); bus.w_reg_write = 1'($urandom);
      bus.w_result = $urandom;
      step();
      if (i == 200) begin
        // asynchronous reset in mid-cycle
        bus.stall = 0; bus.flush = 0;
        load(2'b10, 3'd7, 0, 1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 0);
        step();
        no_fwd();
        #2 reset = 1;
        #1;
        model_reset();
        chk("mid_rst_e_valid", {31'd0, bus.e_valid}, 32'd0);
        chk("mid_rst_ctrl", {29'd0, bus.alu_control}, 32'd7);
        chk("mid_rst_src_a", bus.src_a, 32'd0);
        chk("mid_rst_src_b", bus.src_b, 32'd0);
        @(negedge clk) reset = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
